uart_reg_driver: RTL and testbench
==================================

UART_REG_DRIVER -- requirements
Module: uart_reg_driver

Interface
REQ-001 SHALL have parameter TX_BURST_MAX, default 7, max bytes per TX burst (1..7, 3-bit tx_level limit).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1048575, TX_WAIT watchdog limit (20-bit).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk_i  in  1  clock, all state on rising edge.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 start_i  in  1  one-cycle pulse; begins configuration from IDLE.
REQ-007 cfg_baud_i  in  16  clocks-per-bit value to program.
REQ-008 tx_data_i / tx_valid_i / tx_ready_o  in 8 / in 1 / out 1  TX byte stream, valid/ready.
REQ-009 rx_data_o / rx_valid_o / rx_ready_i  out 8 / out 1 / in 1  RX byte stream, valid/ready.
REQ-010 reg_addr_o / reg_wdata_o / reg_we_o / reg_re_o  out 12 / out 32 / out 1 / out 1  register-bus initiator.
REQ-011 reg_rdata_i  in  32  read data, valid in the same cycle as reg_re_o.
REQ-012 intr_tx_i / intr_rx_i / intr_rx_empty_i  in 1 each  UART core interrupt/status inputs.
REQ-013 busy_o / err_o  out 1 each  not-in-READY indicator / sticky TX timeout flag.

Function
REQ-014 SHALL implement FSM states IDLE, CFG_BAUD, CFG_RXEN, READY, TX_LOAD, TX_LEVEL, TX_GO, TX_WAIT, RX_READ, RX_HOLD.
REQ-015 Register map SHALL be: 0x000 baud, 0x004 TX data, 0x008 RX data, 0x00C RX enable, 0x010 TX FIFO clear, 0x018 TX level, 0x01C TX read-enable.
REQ-016 Every bus access SHALL last exactly one cycle; reg_we_o and reg_re_o SHALL never both be 1; when idle, addr/wdata SHALL be 0.
REQ-017 IDLE + start_i -> CFG_BAUD: write 0x000 with {16'h0, cfg_baud_i}; next cycle CFG_RXEN: write 0x00C with 1; then READY.
REQ-018 start_i outside IDLE SHALL be ignored.
REQ-019 In READY, RX SHALL have priority: intr_rx_i=1 and intr_rx_empty_i=0 -> RX_READ; else tx_valid_i=1 -> TX_LOAD.
REQ-020 tx_ready_o SHALL be 1 only in TX_LOAD while burst count < TX_BURST_MAX; each handshake cycle SHALL write 0x004 with {24'h0, tx_data_i} in that cycle and increment the 3-bit count.
REQ-021 TX_LOAD SHALL exit to TX_LEVEL when count reaches TX_BURST_MAX or tx_valid_i is 0 with count >= 1.
REQ-022 TX_LEVEL SHALL write 0x018 with count; TX_GO SHALL write 0x01C with 1; then TX_WAIT.
REQ-023 TX_WAIT SHALL exit to READY on intr_tx_i=1 (level), clearing count to 0.
REQ-024 RX_READ SHALL assert reg_re_o at 0x008, capture reg_rdata_i[7:0] into rx_data_o, and enter RX_HOLD with rx_valid_o=1.
REQ-025 RX_HOLD SHALL keep rx_data_o stable until rx_ready_i=1, then drop rx_valid_o and return to READY next cycle; no further bus access occurs while holding.
REQ-026 busy_o SHALL be 1 in every state except IDLE and READY.

Reset
REQ-027 On rst_i, asynchronously: state=IDLE, count=0, all outputs 0 (tx_ready_o, rx_valid_o, rx_data_o, reg_*_o, busy_o, err_o).
REQ-028 Reset mid-burst SHALL abort immediately with no further bus writes; a new start_i is required.

Configuration
REQ-029 Macro UART_DRV_TIMEOUT_EN: when defined, a 20-bit counter runs in TX_WAIT; at TIMEOUT_CYCLES without intr_tx_i, err_o sets (sticky until reset), one write of 1 to 0x010 is issued, then READY.
REQ-030 When UART_DRV_TIMEOUT_EN is undefined, TX_WAIT SHALL wait indefinitely, no counter is synthesized, and err_o SHALL be tied 0.

Verification
REQ-031 start_i, cfg_baud_i=16'd868 -> write 0x000=0x364, next cycle 0x00C=1, busy_o returns 0.
REQ-032 Three bytes 0xA5,0x5A,0x3C back-to-back, then valid low -> three writes 0x004, then 0x018=3, 0x01C=1; intr_tx_i=1 -> READY.
REQ-033 Ten bytes continuously valid, TX_BURST_MAX=7 -> tx_ready_o drops after 7, 0x018=7; remaining 3 sent in a second burst.
REQ-034 intr_rx_i=1 while tx_valid_i=1, reg_rdata_i=0x47 -> read 0x008 first; rx_data_o=0x47 held 5 cycles until rx_ready_i.
REQ-035 UART_DRV_TIMEOUT_EN, TIMEOUT_CYCLES=100, intr_tx_i stuck 0 -> err_o=1 after 100 TX_WAIT cycles, write 0x010=1.
REQ-036 rst_i asserted during second TX_LOAD write -> all outputs 0 that cycle; no further bus activity until start_i.

Source files
------------

// File: rtl/uart_reg_driver.sv
// uart_reg_driver: configures a UART core over a simple register bus, then
// moves TX bytes in bursts into the core FIFO and pulls RX bytes out of it.
// Optional feature macro: UART_DRV_TIMEOUT_EN adds a TX_WAIT watchdog that
// flags err_o, clears the TX FIFO and returns to READY.
module uart_reg_driver #(
   parameter int unsigned TX_BURST_MAX   = 7,
   parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [15:0] cfg_baud_i,
   input  logic [7:0]  tx_data_i,
   input  logic        tx_valid_i,
   output logic        tx_ready_o,
   output logic [7:0]  rx_data_o,
   output logic        rx_valid_o,
   input  logic        rx_ready_i,
   output logic [11:0] reg_addr_o,
   output logic [31:0] reg_wdata_o,
   output logic        reg_we_o,
   output logic        reg_re_o,
   input  logic [31:0] reg_rdata_i,
   input  logic        intr_tx_i,
   input  logic        intr_rx_i,
   input  logic        intr_rx_empty_i,
   output logic        busy_o,
   output logic        err_o
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      CFG_BAUD = 4'd1,
      CFG_RXEN = 4'd2,
      READY    = 4'd3,
      TX_LOAD  = 4'd4,
      TX_LEVEL = 4'd5,
      TX_GO    = 4'd6,
      TX_WAIT  = 4'd7,
      RX_READ  = 4'd8,
      RX_HOLD  = 4'd9
   } state_e;

   localparam logic [11:0] ADDR_BAUD    = 12'h000;
   localparam logic [11:0] ADDR_TXDATA  = 12'h004;
   localparam logic [11:0] ADDR_RXDATA  = 12'h008;
   localparam logic [11:0] ADDR_RXEN    = 12'h00C;
   localparam logic [11:0] ADDR_TXCLR   = 12'h010;
   localparam logic [11:0] ADDR_TXLEVEL = 12'h018;
   localparam logic [11:0] ADDR_TXGO    = 12'h01C;
   localparam logic [2:0]  BURST_MAX    = 3'(TX_BURST_MAX);
   localparam logic [2:0]  BURST_LAST   = 3'(TX_BURST_MAX - 1);

   state_e      state_q, state_d;
   logic [2:0]  count_q, count_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        tmo_hit;

`ifdef UART_DRV_TIMEOUT_EN
   localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYCLES - 1);
   logic [19:0] tmo_q, tmo_d;
   logic        err_q;

   assign tmo_hit = (state_q == TX_WAIT) && !intr_tx_i && (tmo_q == TMO_LAST);

   // Watchdog counts consecutive TX_WAIT cycles and restarts elsewhere.
   always_comb begin
      tmo_d = '0;
      if (state_q == TX_WAIT && !intr_tx_i && !tmo_hit) tmo_d = tmo_q + 20'd1;
   end

   // Watchdog counter and sticky timeout flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_q | tmo_hit;
      end
   end

   assign err_o = err_q;
`else
   localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
   assign tmo_hit = 1'b0;
   assign err_o   = 1'b0;
`endif

   assign rx_data_o = rx_data_q;

   // State, burst count and captured RX byte.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         count_q   <= '0;
         rx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         rx_data_q <= rx_data_d;
      end
   end

   // Next-state logic; RX is served ahead of TX when both are pending.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      rx_data_d = rx_data_q;
      case (state_q)
         IDLE:     if (start_i) state_d = CFG_BAUD;
         CFG_BAUD: state_d = CFG_RXEN;
         CFG_RXEN: state_d = READY;
         READY: begin
            if (intr_rx_i && !intr_rx_empty_i) state_d = RX_READ;
            else if (tx_valid_i)               state_d = TX_LOAD;
         end
         TX_LOAD: begin
            if (tx_valid_i && count_q < BURST_MAX) begin
               count_d = count_q + 3'd1;
               if (count_q == BURST_LAST) state_d = TX_LEVEL;
            end else if (!tx_valid_i && count_q != 3'd0) begin
               state_d = TX_LEVEL;
            end
         end
         TX_LEVEL: state_d = TX_GO;
         TX_GO:    state_d = TX_WAIT;
         TX_WAIT: begin
            if (intr_tx_i || tmo_hit) begin
               state_d = READY;
               count_d = '0;
            end
         end
         RX_READ: begin
            rx_data_d = reg_rdata_i[7:0];
            state_d   = RX_HOLD;
         end
         RX_HOLD:  if (rx_ready_i) state_d = READY;
         default:  state_d = IDLE;
      endcase
   end

   // Bus and handshake outputs decoded from the current state.
   always_comb begin
      tx_ready_o  = 1'b0;
      rx_valid_o  = 1'b0;
      reg_addr_o  = '0;
      reg_wdata_o = '0;
      reg_we_o    = 1'b0;
      reg_re_o    = 1'b0;
      busy_o      = 1'b1;
      case (state_q)
         IDLE, READY: busy_o = 1'b0;
         CFG_BAUD: begin
            reg_we_o    = 1'b1;
            reg_addr_o  = ADDR_BAUD;
            reg_wdata_o = {16'h0, cfg_baud_i};
         end
         CFG_RXEN: begin
            reg_we_o    = 1'b1;
            reg_addr_o  = ADDR_RXEN;
            reg_wdata_o = 32'd1;
         end
         TX_LOAD: begin
            tx_ready_o = (count_q < BURST_MAX);
            if (tx_valid_i && count_q < BURST_MAX) begin
               reg_we_o    = 1'b1;
               reg_addr_o  = ADDR_TXDATA;
               reg_wdata_o = {24'h0, tx_data_i};
            end
         end
         TX_LEVEL: begin
            reg_we_o    = 1'b1;
            reg_addr_o  = ADDR_TXLEVEL;
            reg_wdata_o = {29'h0, count_q};
         end
         TX_GO: begin
            reg_we_o    = 1'b1;
            reg_addr_o  = ADDR_TXGO;
            reg_wdata_o = 32'd1;
         end
         TX_WAIT: begin
            if (tmo_hit) begin
               reg_we_o    = 1'b1;
               reg_addr_o  = ADDR_TXCLR;
               reg_wdata_o = 32'd1;
            end
         end
         RX_READ: begin
            reg_re_o   = 1'b1;
            reg_addr_o = ADDR_RXDATA;
         end
         RX_HOLD: rx_valid_o = 1'b1;
         default: busy_o = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_reg_driver.sv
// tb_uart_reg_driver: randomized self-checking bench; a transaction-level
// model predicts the register-bus traffic for each configure/TX/RX activity.
`timescale 1ns/1ps
module tb_uart_reg_driver;

   localparam int MAXB = 7;
`ifdef UART_DRV_TIMEOUT_EN
   localparam int TMO = 100;
`else
   localparam int TMO = 1048575;
`endif

   typedef struct packed {
      logic        rd;
      logic [11:0] addr;
      logic [31:0] data;
      logic [31:0] cyc;
   } op_t;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [15:0] cfg_baud_i;
   logic [7:0]  tx_data_i;
   logic        tx_valid_i;
   logic        tx_ready_o;
   logic [7:0]  rx_data_o;
   logic        rx_valid_o;
   logic        rx_ready_i;
   logic [11:0] reg_addr_o;
   logic [31:0] reg_wdata_o;
   logic        reg_we_o;
   logic        reg_re_o;
   logic [31:0] reg_rdata_i;
   logic        intr_tx_i = 1'b0;
   logic        intr_rx_i;
   logic        intr_rx_empty_i;
   logic        busy_o;
   logic        err_o;

   int          checks = 0;
   int          errors = 0;
   int          proto_err = 0;
   int unsigned cyc = 0;
   bit          auto_ack = 1'b1;

   op_t         obs_q[$];
   op_t         exp_q[$];
   logic [7:0]  tx_src[$];
   int          exp_run[$];
   int          obs_run[$];

   uart_reg_driver #(.TX_BURST_MAX(MAXB), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .cfg_baud_i(cfg_baud_i),
      .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
      .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
      .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_we_o(reg_we_o),
      .reg_re_o(reg_re_o), .reg_rdata_i(reg_rdata_i), .intr_tx_i(intr_tx_i),
      .intr_rx_i(intr_rx_i), .intr_rx_empty_i(intr_rx_empty_i),
      .busy_o(busy_o), .err_o(err_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bus monitor: log every access and count protocol violations.
   always @(negedge clk) begin
      if (reg_we_o && reg_re_o) proto_err++;
      if (!reg_we_o && !reg_re_o && (reg_addr_o !== 12'h0 || reg_wdata_o !== 32'h0)) proto_err++;
      if (reg_we_o || reg_re_o)
         obs_q.push_back('{rd: reg_re_o, addr: reg_addr_o, data: reg_wdata_o, cyc: 32'(cyc)});
   end

   // UART core stand-in: raise intr_tx a few cycles after each TX go.
   always begin : tx_responder
      int unsigned ack_dly;
      @(negedge clk);
      if (auto_ack && reg_we_o && reg_addr_o == 12'h01C) begin
         ack_dly = $urandom_range(4, 1);
         repeat (ack_dly) @(posedge clk);
         #1 intr_tx_i = 1'b1;
         @(posedge clk);
         #1 intr_tx_i = 1'b0;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

   function automatic op_t mk(input logic rd, input logic [11:0] a, input logic [31:0] d);
      op_t o;
      o.rd = rd; o.addr = a; o.data = d; o.cyc = '0;
      return o;
   endfunction

   function automatic void model_cfg(input logic [15:0] baud);
      exp_q.push_back(mk(1'b0, 12'h000, {16'h0, baud}));
      exp_q.push_back(mk(1'b0, 12'h00C, 32'd1));
   endfunction

   // Bytes are split into bursts of at most MAXB, each closed by level + go.
   function automatic void model_tx();
      int n = tx_src.size();
      int i = 0;
      while (i < n) begin
         int len;
         len = (n - i > MAXB) ? MAXB : n - i;
         for (int j = 0; j < len; j++) exp_q.push_back(mk(1'b0, 12'h004, {24'h0, tx_src[i+j]}));
         exp_q.push_back(mk(1'b0, 12'h018, 32'(len)));
         exp_q.push_back(mk(1'b0, 12'h01C, 32'd1));
         exp_run.push_back(len);
         i += len;
      end
   endfunction

   task automatic drive_tx();
      int guard = 0;
      int run = 0;
      bit hs;
      obs_run.delete();
      @(posedge clk); #1;
      while (tx_src.size() > 0 && guard < 1000) begin
         tx_valid_i = 1'b1;
         tx_data_i  = tx_src[0];
         @(negedge clk);
         hs = tx_ready_o;
         if (hs) run++;
         else if (run > 0) begin obs_run.push_back(run); run = 0; end
         @(posedge clk); #1;
         if (hs) void'(tx_src.pop_front());
         guard++;
      end
      if (run > 0) obs_run.push_back(run);
      tx_valid_i = 1'b0;
      checks++;
      if (tx_src.size() != 0) begin
         errors++;
         $display("FAIL tx_drain: %0d bytes left after %0d cycles, want 0", tx_src.size(), guard);
      end
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      do begin @(negedge clk); n++; end while (busy_o !== 1'b0 && n < budget);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL %s_idle: busy_o=%b after %0d cycles, want 0", name, busy_o, n);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; start_i = 1'b1; tx_valid_i = 1'b1; intr_rx_i = 1'b1; intr_rx_empty_i = 1'b0;
      cfg_baud_i = 16'hFFFF; tx_data_i = 8'hFF; rx_ready_i = 1'b0; reg_rdata_i = 32'hFFFF_FFFF;
      #1;
      checks++;
      if ({tx_ready_o, rx_valid_o, rx_data_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o, busy_o, err_o} !== '0) begin
         errors++;
         $display("FAIL reset_async: outputs=%h, want 0",
                  {tx_ready_o, rx_valid_o, rx_data_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o, busy_o, err_o});
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({tx_ready_o, rx_valid_o, rx_data_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o, busy_o, err_o} !== '0) begin
         errors++;
         $display("FAIL reset_held: outputs=%h, want 0",
                  {tx_ready_o, rx_valid_o, rx_data_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o, busy_o, err_o});
      end
      start_i = 1'b0; tx_valid_i = 1'b0; intr_rx_i = 1'b0; intr_rx_empty_i = 1'b1;
      rst_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0 || reg_we_o !== 1'b0 || reg_re_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_start: busy=%b we=%b re=%b, want 0 0 0", busy_o, reg_we_o, reg_re_o);
      end
   endtask

   task automatic test_config(input logic [15:0] baud);
      int base = obs_q.size();
      exp_q.delete();
      model_cfg(baud);
      @(posedge clk); #1;
      start_i = 1'b1; cfg_baud_i = baud;
      @(posedge clk); #1;
      start_i = 1'b0;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b1) begin errors++; $display("FAIL cfg_busy: busy_o=%b, want 1", busy_o); end
      wait_idle("cfg", 10);
      checks++;
      if (obs_q.size() - base != exp_q.size()) begin
         errors++;
         $display("FAIL cfg_count: %0d accesses, want %0d", obs_q.size() - base, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[base+i].rd !== exp_q[i].rd || obs_q[base+i].addr !== exp_q[i].addr ||
             obs_q[base+i].data !== exp_q[i].data) begin
            errors++;
            $display("FAIL cfg_op%0d: got rd=%b addr=%h data=%h, want rd=%b addr=%h data=%h", i,
                     obs_q[base+i].rd, obs_q[base+i].addr, obs_q[base+i].data,
                     exp_q[i].rd, exp_q[i].addr, exp_q[i].data);
         end
      end
      if (obs_q.size() - base == 2) begin
         checks++;
         if (obs_q[base+1].cyc !== obs_q[base].cyc + 1) begin
            errors++;
            $display("FAIL cfg_spacing: gap %0d cycles, want 1", obs_q[base+1].cyc - obs_q[base].cyc);
         end
      end
   endtask

   task automatic test_start_ignored();
      int base = obs_q.size();
      @(posedge clk); #1;
      start_i = 1'b1; cfg_baud_i = 16'($urandom);
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (obs_q.size() != base || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL start_ignored: %0d accesses busy=%b, want 0 accesses busy=0", obs_q.size() - base, busy_o);
      end
   endtask

   task automatic run_tx_burst(input string name);
      int base = obs_q.size();
      exp_q.delete(); exp_run.delete();
      model_tx();
      drive_tx();
      wait_idle(name, 200);
      checks++;
      if (obs_q.size() - base != exp_q.size()) begin
         errors++;
         $display("FAIL %s_count: %0d accesses, want %0d", name, obs_q.size() - base, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[base+i].rd !== exp_q[i].rd || obs_q[base+i].addr !== exp_q[i].addr ||
             obs_q[base+i].data !== exp_q[i].data) begin
            errors++;
            $display("FAIL %s_op%0d: got rd=%b addr=%h data=%h, want rd=%b addr=%h data=%h", name, i,
                     obs_q[base+i].rd, obs_q[base+i].addr, obs_q[base+i].data,
                     exp_q[i].rd, exp_q[i].addr, exp_q[i].data);
         end
         if (i > 0 && (exp_q[i].addr == 12'h01C || (exp_q[i].addr == 12'h004 && exp_q[i-1].addr == 12'h004))) begin
            checks++;
            if (obs_q[base+i].cyc !== obs_q[base+i-1].cyc + 1) begin
               errors++;
               $display("FAIL %s_gap%0d: gap %0d cycles, want 1", name, i, obs_q[base+i].cyc - obs_q[base+i-1].cyc);
            end
         end
      end
      checks++;
      if (obs_run != exp_run) begin
         errors++;
         $display("FAIL %s_ready_runs: got %p, want %p", name, obs_run, exp_run);
      end
   endtask

   task automatic test_tx_burst();
      tx_src.delete();
      tx_src.push_back(8'hA5); tx_src.push_back(8'h5A); tx_src.push_back(8'h3C);
      run_tx_burst("tx3");
   endtask

   task automatic test_back_to_back();
      tx_src.delete();
      for (int i = 0; i < 10; i++) tx_src.push_back(8'($urandom));
      run_tx_burst("tx10");
      for (int k = 0; k < 3; k++) begin
         int n = $urandom_range(16, 1);
         tx_src.delete();
         for (int i = 0; i < n; i++) tx_src.push_back(8'($urandom));
         run_tx_burst("txrand");
      end
   endtask

   task automatic test_rx_priority(input logic [7:0] rd);
      int base = obs_q.size();
      logic [7:0] b = 8'($urandom);
      exp_q.delete(); exp_run.delete();
      exp_q.push_back(mk(1'b1, 12'h008, 32'h0));
      tx_src.delete(); tx_src.push_back(b);
      model_tx();
      @(posedge clk); #1;
      intr_rx_i = 1'b1; intr_rx_empty_i = 1'b0; reg_rdata_i = {24'($urandom), rd};
      tx_valid_i = 1'b1; tx_data_i = b;
      @(posedge clk); #1;
      intr_rx_i = 1'b0; intr_rx_empty_i = 1'b1;
      @(posedge clk); #1;
      reg_rdata_i = $urandom;
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (rx_valid_o !== 1'b1 || rx_data_o !== rd || reg_we_o !== 1'b0 || reg_re_o !== 1'b0 || tx_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL rx_hold: valid=%b data=%h we=%b re=%b txr=%b, want 1 %h 0 0 0",
                     rx_valid_o, rx_data_o, reg_we_o, reg_re_o, tx_ready_o, rd);
         end
         @(posedge clk); #1;
      end
      rx_ready_i = 1'b1;
      @(posedge clk); #1;
      rx_ready_i = 1'b0;
      @(negedge clk);
      checks++;
      if (rx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL rx_release: valid=%b busy=%b, want 0 0", rx_valid_o, busy_o);
      end
      drive_tx();
      wait_idle("rx", 200);
      checks++;
      if (obs_q.size() - base != exp_q.size()) begin
         errors++;
         $display("FAIL rx_count: %0d accesses, want %0d", obs_q.size() - base, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[base+i].rd !== exp_q[i].rd || obs_q[base+i].addr !== exp_q[i].addr ||
             (!exp_q[i].rd && obs_q[base+i].data !== exp_q[i].data)) begin
            errors++;
            $display("FAIL rx_op%0d: got rd=%b addr=%h data=%h, want rd=%b addr=%h data=%h", i,
                     obs_q[base+i].rd, obs_q[base+i].addr, obs_q[base+i].data,
                     exp_q[i].rd, exp_q[i].addr, exp_q[i].data);
         end
      end
   endtask

`ifdef UART_DRV_TIMEOUT_EN
   task automatic test_timeout();
      int base = obs_q.size();
      int err_cyc = -1;
      int n = 0;
      auto_ack = 1'b0;
      exp_q.delete(); exp_run.delete();
      tx_src.delete(); tx_src.push_back(8'($urandom));
      model_tx();
      exp_q.push_back(mk(1'b0, 12'h010, 32'd1));
      drive_tx();
      checks++;
      if (err_o !== 1'b0) begin errors++; $display("FAIL tmo_early: err_o=%b, want 0", err_o); end
      while (err_cyc < 0 && n < TMO + 50) begin
         @(negedge clk);
         n++;
         if (err_o === 1'b1) err_cyc = int'(cyc);
      end
      checks++;
      if (err_cyc < 0) begin errors++; $display("FAIL tmo_err: err_o=%b after %0d cycles, want 1", err_o, n); end
      wait_idle("tmo", 10);
      checks++;
      if (obs_q.size() - base != exp_q.size()) begin
         errors++;
         $display("FAIL tmo_count: %0d accesses, want %0d", obs_q.size() - base, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[base+i].rd !== exp_q[i].rd || obs_q[base+i].addr !== exp_q[i].addr ||
             obs_q[base+i].data !== exp_q[i].data) begin
            errors++;
            $display("FAIL tmo_op%0d: got rd=%b addr=%h data=%h, want rd=%b addr=%h data=%h", i,
                     obs_q[base+i].rd, obs_q[base+i].addr, obs_q[base+i].data,
                     exp_q[i].rd, exp_q[i].addr, exp_q[i].data);
         end
      end
      if (obs_q.size() - base == 4) begin
         checks++;
         if (obs_q[base+3].cyc - obs_q[base+2].cyc !== 32'(TMO) || err_cyc != int'(obs_q[base+3].cyc) + 1) begin
            errors++;
            $display("FAIL tmo_timing: clear %0d cycles after go, err at +%0d, want %0d and +1",
                     obs_q[base+3].cyc - obs_q[base+2].cyc, err_cyc - int'(obs_q[base+3].cyc), TMO);
         end
      end
      auto_ack = 1'b1;
      tx_src.delete(); tx_src.push_back(8'($urandom));
      drive_tx();
      wait_idle("tmo_sticky", 200);
      checks++;
      if (err_o !== 1'b1) begin errors++; $display("FAIL tmo_sticky: err_o=%b, want 1", err_o); end
   endtask
`endif

   task automatic test_reset_midburst();
      int base = obs_q.size();
      logic [7:0] d0 = 8'($urandom);
      logic [7:0] d1 = 8'($urandom);
      @(posedge clk); #1;
      tx_valid_i = 1'b1; tx_data_i = d0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      tx_data_i = d1;
      #1;
      checks++;
      if (reg_we_o !== 1'b1 || reg_wdata_o !== {24'h0, d1}) begin
         errors++;
         $display("FAIL midburst_second: we=%b data=%h, want 1 %h", reg_we_o, reg_wdata_o, {24'h0, d1});
      end
      rst_i = 1'b1;
      #1;
      checks++;
      if ({tx_ready_o, rx_valid_o, rx_data_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o, busy_o, err_o} !== '0) begin
         errors++;
         $display("FAIL midburst_reset: outputs=%h, want 0",
                  {tx_ready_o, rx_valid_o, rx_data_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o, busy_o, err_o});
      end
      @(posedge clk); #1;
      rst_i = 1'b0; intr_rx_i = 1'b1; intr_rx_empty_i = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs_q.size() - base != 1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL midburst_quiet: %0d accesses busy=%b, want 1 access busy=0", obs_q.size() - base, busy_o);
      end else begin
         checks++;
         if (obs_q[base].addr !== 12'h004 || obs_q[base].data !== {24'h0, d0}) begin
            errors++;
            $display("FAIL midburst_first: addr=%h data=%h, want 004 %h", obs_q[base].addr, obs_q[base].data, {24'h0, d0});
         end
      end
      @(posedge clk); #1;
      tx_valid_i = 1'b0; intr_rx_i = 1'b0; intr_rx_empty_i = 1'b1;
      test_config(16'($urandom));
   endtask

   initial begin
      test_reset();
      test_config(16'd868);
      test_start_ignored();
      test_tx_burst();
      test_back_to_back();
      test_rx_priority(8'h47);
      test_rx_priority(8'($urandom));
`ifdef UART_DRV_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_midburst();
      checks++;
      if (proto_err != 0) begin
         errors++;
         $display("FAIL bus_protocol: %0d violating cycles, want 0", proto_err);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
